// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter: FSM states, bus widths
// and the round-robin eligible-requester search.
package sdram_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Walks the candidates from the farthest to the nearest so the requester
   // closest to the start pointer is the one left in pick.
   function automatic logic [1:0] next_eligible(input logic [3:0] elig,
                                                input int start,
                                                input int n_req);
      logic [1:0] pick;
      int         idx;
      pick = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (k < n_req) begin
            idx = (start + k) % n_req;
            if (elig[idx]) begin
               pick = idx[1:0];
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO recording which requester owns each outstanding SDRAM read, so read
// data can be routed back in issue order. DEPTH must be a power of two (>= 2).
module sdram_arb_tag_fifo
   import sdram_arb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [TAG_W-1:0] push_tag,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [TAG_W-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [TAG_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally at DEPTH; a simultaneous push and pop leaves count alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_tag;
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM port between N_REQ masters.
// Define SDRAM_ARB_FIXED_PRI_EN for fixed priority (requester 0 highest).
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int N_REQ     = 2,
   parameter int TAG_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ*ADDR_W-1:0] req_address,
   input  logic [N_REQ-1:0]        req_read,
   input  logic [N_REQ-1:0]        req_write,
   input  logic [N_REQ*DATA_W-1:0] req_writedata,
   output logic [N_REQ-1:0]        req_waitrequest,
   output logic [N_REQ*DATA_W-1:0] req_readdata,
   output logic [N_REQ-1:0]        req_readdatavalid,
   input  logic                    m_waitrequest,
   output logic [ADDR_W-1:0]       m_address,
   output logic                    m_read,
   output logic                    m_write,
   output logic [DATA_W-1:0]       m_writedata,
   input  logic [DATA_W-1:0]       m_readdata,
   input  logic                    m_readdatavalid,
   output logic                    rsp_orphan
);

   localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(N_REQ - 1);

   logic [0:0]       state;
   logic [TAG_W-1:0] grant_idx;
   logic [N_REQ-1:0] elig;
   logic [3:0]       elig_pad;
   logic             any_elig;
   logic [TAG_W-1:0] pick;
   logic             accept;
   logic             grant_active;
   logic             fifo_full;
   logic             fifo_empty;
   logic             tag_push;
   logic             tag_pop;
   logic [TAG_W-1:0] head_tag;
`ifndef SDRAM_ARB_FIXED_PRI_EN
   logic [TAG_W-1:0] rr_ptr;
`endif

   // A read only competes while there is room to remember who issued it.
   always_comb begin
      elig     = req_write | (req_read & {N_REQ{~fifo_full}});
      elig_pad = '0;
      elig_pad[N_REQ-1:0] = elig;
      any_elig = |elig;
`ifdef SDRAM_ARB_FIXED_PRI_EN
      pick = TAG_W'(next_eligible(elig_pad, 0, N_REQ));
`else
      pick = TAG_W'(next_eligible(elig_pad, int'(rr_ptr), N_REQ));
`endif
   end

   assign accept       = (state == GRANT) && (m_read || m_write) && !m_waitrequest;
   assign grant_active = req_read[grant_idx] || req_write[grant_idx];
   assign tag_push     = accept && m_read;
   assign tag_pop      = m_readdatavalid && !fifo_empty;

   always_comb begin
      req_waitrequest = '1;
      if (state == GRANT) begin
         req_waitrequest[grant_idx] = m_waitrequest;
      end
   end

   // Write beats read when a requester asserts both, so no tag is taken for it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant_idx   <= '0;
         m_address   <= '0;
         m_writedata <= '0;
         m_read      <= 1'b0;
         m_write     <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRI_EN
         rr_ptr      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_elig) begin
                  state       <= GRANT;
                  grant_idx   <= pick;
                  m_address   <= req_address[ADDR_W*int'(pick) +: ADDR_W];
                  m_writedata <= req_writedata[DATA_W*int'(pick) +: DATA_W];
                  m_write     <= req_write[pick];
                  m_read      <= req_read[pick] && !req_write[pick];
               end
            end
            GRANT: begin
               if (accept) begin
                  state   <= IDLE;
                  m_read  <= 1'b0;
                  m_write <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRI_EN
                  rr_ptr  <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
`endif
               end else if (!grant_active) begin
                  state   <= IDLE;
                  m_read  <= 1'b0;
                  m_write <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read data goes to the oldest tag; data with no tag behind it is flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_readdata      <= '0;
         req_readdatavalid <= '0;
         rsp_orphan        <= 1'b0;
      end else begin
         req_readdatavalid <= '0;
         if (m_readdatavalid) begin
            if (!fifo_empty) begin
               req_readdatavalid[head_tag]                   <= 1'b1;
               req_readdata[DATA_W*int'(head_tag) +: DATA_W] <= m_readdata;
            end else begin
               rsp_orphan <= 1'b1;
            end
         end
      end
   end

   sdram_arb_tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .TAG_W (TAG_W)
   ) u_tag_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (tag_push),
      .push_tag (grant_idx),
      .pop      (tag_pop),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (head_tag)
   );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: requester drivers, an SDRAM model with
// controllable stall/latency, and scoreboards for transactions and read responses.
module tb_sdram_arbiter;

   localparam int N_REQ     = 2;
   localparam int TAG_DEPTH = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [N_REQ*32-1:0] req_address;
   logic [N_REQ-1:0]    req_read;
   logic [N_REQ-1:0]    req_write;
   logic [N_REQ*32-1:0] req_writedata;
   logic [N_REQ-1:0]    req_waitrequest;
   logic [N_REQ*32-1:0] req_readdata;
   logic [N_REQ-1:0]    req_readdatavalid;
   logic                m_waitrequest;
   logic [31:0]         m_address;
   logic                m_read;
   logic                m_write;
   logic [31:0]         m_writedata;
   logic [31:0]         m_readdata = '0;
   logic                m_readdatavalid = 1'b0;
   logic                rsp_orphan;

   typedef struct {
      int          req;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   typedef struct {
      int          req;
      logic [31:0] data;
   } rsp_t;

   typedef struct {
      logic [31:0] data;
      longint      ready;
   } pend_t;

   txn_t   exp_txn[$];
   rsp_t   exp_rsp[$];
   pend_t  rd_pending[$];
   int     grant_log[$];
   int     tests = 0;
   int     errors = 0;
   longint cyc = 0;
   bit     sd_hold = 1'b0;
   bit     force_rdv = 1'b0;
   int     rsp_seen = 0;
   int     rsp_at_5th = -1;
   int     lat0;
   int     lat1;
   int     mon_r;
   int     mon_zeros;
   int     mon_idx;
   pend_t  mon_p;
   int     rr_exp[4] = '{0, 1, 0, 1};

   sdram_arbiter #(
      .N_REQ     (N_REQ),
      .TAG_DEPTH (TAG_DEPTH)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .req_address       (req_address),
      .req_read          (req_read),
      .req_write         (req_write),
      .req_writedata     (req_writedata),
      .req_waitrequest   (req_waitrequest),
      .req_readdata      (req_readdata),
      .req_readdatavalid (req_readdatavalid),
      .m_waitrequest     (m_waitrequest),
      .m_address         (m_address),
      .m_read            (m_read),
      .m_write           (m_write),
      .m_writedata       (m_writedata),
      .m_readdata        (m_readdata),
      .m_readdatavalid   (m_readdatavalid),
      .rsp_orphan        (rsp_orphan)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // SDRAM model: read data is address>>4, returned at least two cycles after acceptance.
   always @(posedge clk) begin
      #1;
      if (force_rdv) begin
         m_readdatavalid = 1'b1;
         m_readdata      = 32'hBAD0_0000;
         force_rdv       = 1'b0;
      end else if (!rst && !sd_hold && rd_pending.size() > 0 && rd_pending[0].ready <= cyc) begin
         m_readdatavalid = 1'b1;
         m_readdata      = rd_pending[0].data;
         void'(rd_pending.pop_front());
      end else begin
         m_readdatavalid = 1'b0;
         m_readdata      = '0;
      end
   end

   // Transaction and response monitors, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if ((m_read || m_write) && !m_waitrequest) begin
            mon_r     = -1;
            mon_zeros = 0;
            for (int i = 0; i < N_REQ; i++) begin
               if (!req_waitrequest[i]) begin
                  mon_r = i;
                  mon_zeros++;
               end
            end
            checkOutput("accept_onehot", mon_zeros, 1);
            if (mon_r >= 0) begin
               grant_log.push_back(mon_r);
               mon_idx = -1;
               for (int i = 0; i < exp_txn.size(); i++) begin
                  if (mon_idx < 0 && exp_txn[i].req == mon_r) mon_idx = i;
               end
               if (mon_idx < 0) begin
                  checkOutput("txn_extra", {30'd0, m_write, m_read}, 32'd0);
               end else begin
                  checkOutput("txn_addr", m_address, exp_txn[mon_idx].addr);
                  checkOutput("txn_write", m_write, exp_txn[mon_idx].wr);
                  checkOutput("txn_read", m_read, !exp_txn[mon_idx].wr);
                  if (exp_txn[mon_idx].wr) checkOutput("txn_wdata", m_writedata, exp_txn[mon_idx].data);
                  exp_txn.delete(mon_idx);
               end
               if (m_read) begin
                  mon_p.data  = m_address >> 4;
                  mon_p.ready = cyc + 2;
                  rd_pending.push_back(mon_p);
                  if (mon_r == 0 && m_address == 32'h240) rsp_at_5th = rsp_seen;
               end
            end
         end
         if (req_readdatavalid != '0) begin
            rsp_seen++;
            checkOutput("rsp_onehot", $countones(req_readdatavalid), 1);
            for (int i = 0; i < N_REQ; i++) begin
               if (req_readdatavalid[i]) begin
                  mon_idx = -1;
                  for (int j = 0; j < exp_rsp.size(); j++) begin
                     if (mon_idx < 0 && exp_rsp[j].req == i) mon_idx = j;
                  end
                  if (mon_idx < 0) begin
                     checkOutput("rsp_extra", {30'd0, req_readdatavalid}, 32'd0);
                  end else begin
                     checkOutput("rsp_data", req_readdata[32*i +: 32], exp_rsp[mon_idx].data);
                     exp_rsp.delete(mon_idx);
                  end
               end
            end
         end
      end
   end

   // kind: 0 read, 1 write, 2 read+write together. Call at posedge+1.
   task automatic applyStimulus(input int r, input int kind, input logic [31:0] addr,
                                input logic [31:0] data, output int lat);
      txn_t t;
      rsp_t e;
      t.req  = r;
      t.wr   = (kind != 0);
      t.addr = addr;
      t.data = data;
      exp_txn.push_back(t);
      if (kind == 0) begin
         e.req  = r;
         e.data = addr >> 4;
         exp_rsp.push_back(e);
      end
      req_address[32*r +: 32]   = addr;
      req_writedata[32*r +: 32] = data;
      req_read[r]  = (kind != 1);
      req_write[r] = (kind != 0);
      lat = 0;
      forever begin
         @(negedge clk);
         lat++;
         if (rst) break;
         if (!req_waitrequest[r]) break;
         if (lat > 300) begin
            checkOutput("issue_timeout", lat, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
      req_read[r]  = 1'b0;
      req_write[r] = 1'b0;
   endtask

   task automatic applyReset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_txn.delete();
      exp_rsp.delete();
      rd_pending.delete();
      grant_log.delete();
   endtask

   task automatic waitDrain(input string tag);
      for (int i = 0; i < 200 && (exp_rsp.size() != 0 || exp_txn.size() != 0); i++) @(negedge clk);
      checkOutput({tag, "_drain_txn"}, exp_txn.size(), 0);
      checkOutput({tag, "_drain_rsp"}, exp_rsp.size(), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst           = 1'b1;
      req_address   = '0;
      req_read      = '0;
      req_write     = '0;
      req_writedata = '0;
      m_waitrequest = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_waitreq", req_waitrequest, 2'b11);
      checkOutput("rst_m_read", m_read, 0);
      checkOutput("rst_m_write", m_write, 0);
      checkOutput("rst_orphan", rsp_orphan, 0);
      checkOutput("rst_rdvalid", req_readdatavalid, 2'b00);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Round-robin contention, both requesters streaming reads
      $display("[TB] round-robin reads");
      fork
         begin
            applyStimulus(0, 0, 32'hA0, 32'h0, lat0);
            applyStimulus(0, 0, 32'hC0, 32'h0, lat0);
         end
         begin
            applyStimulus(1, 0, 32'hB0, 32'h0, lat1);
            applyStimulus(1, 0, 32'hD0, 32'h0, lat1);
         end
      join
      waitDrain("rr");
      checkOutput("rr_grant_count", grant_log.size(), 4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++) checkOutput("rr_grant_order", grant_log[i], rr_exp[i]);

      // Single write and its latency
      $display("[TB] single write");
      applyReset();
      applyStimulus(0, 1, 32'h100, 32'hDEAD_BEEF, lat0);
      checkOutput("wr_latency", lat0, 2);
      waitDrain("wr");

      // Tag FIFO full: fifth read stalls, writes still flow
      $display("[TB] tag full");
      applyReset();
      sd_hold    = 1'b1;
      rsp_seen   = 0;
      rsp_at_5th = -1;
      fork
         begin
            for (int k = 0; k < 5; k++) applyStimulus(0, 0, 32'h200 + 32'(16 * k), 32'h0, lat0);
         end
      join_none
      repeat (16) @(negedge clk);
      checkOutput("full_stall_wreq", req_waitrequest[0], 1);
      checkOutput("full_no_read", m_read, 0);
      checkOutput("full_pending", exp_txn.size(), 1);
      @(posedge clk);
      #1;
      applyStimulus(1, 1, 32'h300, 32'h1234_5678, lat1);
      checkOutput("full_write_lat", lat1, 2);
      @(negedge clk);
      checkOutput("full_still_stall", req_waitrequest[0], 1);
      checkOutput("full_no_rsp_yet", rsp_seen, 0);
      sd_hold = 1'b0;
      wait fork;
      waitDrain("full");
      checkOutput("full_5th_after_rdv", rsp_at_5th > 0, 1);

      // Read+write together counts as a write; then an untagged response is orphaned
      $display("[TB] write wins and orphan");
      applyReset();
      applyStimulus(0, 2, 32'h500, 32'hCAFE_F00D, lat0);
      waitDrain("ww");
      @(negedge clk);
      force_rdv = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("orphan_set", rsp_orphan, 1);
      checkOutput("orphan_no_rdvalid", req_readdatavalid, 2'b00);
      repeat (3) @(negedge clk);
      checkOutput("orphan_sticky", rsp_orphan, 1);

      // Reset during GRANT with two reads outstanding
      $display("[TB] mid-grant reset");
      applyReset();
      checkOutput("mg_orphan_cleared", rsp_orphan, 0);
      sd_hold = 1'b1;
      applyStimulus(0, 0, 32'h600, 32'h0, lat0);
      applyStimulus(0, 0, 32'h610, 32'h0, lat0);
      m_waitrequest = 1'b1;
      fork
         applyStimulus(1, 1, 32'h700, 32'h5555_AAAA, lat1);
      join_none
      repeat (2) @(negedge clk);
      checkOutput("mg_in_grant", m_write, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("mg_waitreq", req_waitrequest, 2'b11);
      checkOutput("mg_m_write", m_write, 0);
      checkOutput("mg_m_read", m_read, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait fork;
      exp_txn.delete();
      exp_rsp.delete();
      rd_pending.delete();
      m_waitrequest = 1'b0;
      sd_hold       = 1'b0;
      @(negedge clk);
      force_rdv = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("mg_fifo_empty", rsp_orphan, 1);
      checkOutput("mg_no_rdvalid", req_readdatavalid, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
